// File: rtl/tcp_vlg_pkg.sv
// Shared types and constants for the TCP engine slice: delayed-ACK reason
// encoding and the saturating byte accumulator used by the ACK trackers.
package tcp_vlg_pkg;

    localparam int ACK_RSN_W   = 7;
    localparam int ACK_BYTES_W = 17;

    localparam int RSN_TIMEOUT = 0;
    localparam int RSN_PKTS    = 1;
    localparam int RSN_BYTES   = 2;
    localparam int RSN_OOO     = 3;
    localparam int RSN_PSH     = 4;
    localparam int RSN_SACK    = 5;
    localparam int RSN_WIN     = 6;

    typedef struct packed {
        logic win;
        logic sack;
        logic psh;
        logic ooo;
        logic bytes;
        logic pkts;
        logic timeout;
    } ack_reason_t;

    function automatic logic [ACK_BYTES_W-1:0] sat_add_bytes(
        input logic [ACK_BYTES_W-1:0] acc,
        input logic [15:0]            len
    );
        logic [ACK_BYTES_W:0] sum;
        sum = {1'b0, acc} + {2'b00, len};
        if (sum[ACK_BYTES_W]) begin
            return {ACK_BYTES_W{1'b1}};
        end else begin
            return sum[ACK_BYTES_W-1:0];
        end
    endfunction

endpackage

// File: rtl/tcp_vlg_ack_chan.sv
// Per-connection delayed-ACK tracker: unacked timer, packet and byte counters,
// trigger evaluation and the pending/reason flags presented to the arbiter.
module tcp_vlg_ack_chan
    import tcp_vlg_pkg::*;
#(
    parameter int TIMEOUT           = 1250,
    parameter int FORCE_ACK_PACKETS = 5,
    parameter int FORCE_ACK_BYTES   = 2920,
    parameter int IMM_OOO           = 1,
    parameter int IMM_PSH           = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 connected,
    input  logic                 rx_val,
    input  logic [31:0]          rx_seq_end,
    input  logic [15:0]          rx_len,
    input  logic                 rx_psh,
    input  logic [31:0]          loc_ack,
    input  logic [31:0]          rep_ack,
    input  logic                 sack_upd,
    input  logic                 win_upd,
    input  logic                 done,
    output logic                 pending,
    output logic [ACK_RSN_W-1:0] reason
);

    localparam int TW = $clog2(TIMEOUT + 32'sd1);
    localparam int PW = $clog2(FORCE_ACK_PACKETS + 32'sd1);
    localparam int BW = ACK_BYTES_W + 32'sd1;

    localparam logic [TW-1:0] TMR_MAX   = TW'(TIMEOUT);
    localparam logic [TW-1:0] TMR_FIRE  = TW'(TIMEOUT - 32'sd1);
    localparam logic [PW-1:0] PKT_MAX   = PW'(FORCE_ACK_PACKETS);
    localparam logic [BW-1:0] BYTES_LIM = BW'(FORCE_ACK_BYTES);
    localparam logic          BYTES_EN  = (FORCE_ACK_BYTES != 32'sd0);
    localparam logic          OOO_EN    = (IMM_OOO != 32'sd0);
    localparam logic          PSH_EN    = (IMM_PSH != 32'sd0);

    logic                   acked_r;
    logic [TW-1:0]          timer_r;
    logic [PW-1:0]          pkts_r;
    logic [ACK_BYTES_W-1:0] bytes_r;
    logic                   pending_r;
    logic [ACK_RSN_W-1:0]   reason_r;

    logic                   ooo_s;
    logic [ACK_RSN_W-1:0]   trig_s;
    logic [TW-1:0]          timer_nxt_s;
    logic [PW-1:0]          pkts_nxt_s;
    logic [ACK_BYTES_W-1:0] bytes_nxt_s;

    assign pending = pending_r;
    assign reason  = reason_r;

    // Trigger evaluation; nothing fires while the connection is down.
    always_comb begin
        ooo_s  = rx_val && (rx_seq_end != loc_ack);
        trig_s = {ACK_RSN_W{1'b0}};
        if (connected) begin
            trig_s[RSN_TIMEOUT] = (timer_r == TMR_FIRE);
            trig_s[RSN_PKTS]    = (pkts_r == PKT_MAX) && !acked_r;
            trig_s[RSN_BYTES]   = BYTES_EN && ({1'b0, bytes_r} >= BYTES_LIM);
            trig_s[RSN_OOO]     = OOO_EN && ooo_s;
            trig_s[RSN_PSH]     = PSH_EN && rx_val && rx_psh;
            trig_s[RSN_SACK]    = sack_upd;
            trig_s[RSN_WIN]     = win_upd;
        end else begin
            trig_s = {ACK_RSN_W{1'b0}};
        end
    end

    // Next counter values; an out-of-order segment restarts the timer but still counts.
    always_comb begin
        timer_nxt_s = {TW{1'b0}};
        pkts_nxt_s  = {PW{1'b0}};
        bytes_nxt_s = {ACK_BYTES_W{1'b0}};
        if (!connected || acked_r || done) begin
            timer_nxt_s = {TW{1'b0}};
        end else begin
            if (ooo_s) begin
                timer_nxt_s = {TW{1'b0}};
            end else if (timer_r == TMR_MAX) begin
                timer_nxt_s = timer_r;
            end else begin
                timer_nxt_s = timer_r + TW'(1'b1);
            end
            if (rx_val) begin
                pkts_nxt_s  = (pkts_r == PKT_MAX) ? pkts_r : pkts_r + PW'(1'b1);
                bytes_nxt_s = sat_add_bytes(bytes_r, rx_len);
            end else begin
                pkts_nxt_s  = pkts_r;
                bytes_nxt_s = bytes_r;
            end
        end
    end

    // Channel state registers; a completion keeps only triggers seen in that same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            acked_r   <= 1'b0;
            timer_r   <= {TW{1'b0}};
            pkts_r    <= {PW{1'b0}};
            bytes_r   <= {ACK_BYTES_W{1'b0}};
            pending_r <= 1'b0;
            reason_r  <= {ACK_RSN_W{1'b0}};
        end else begin
            acked_r <= (loc_ack == rep_ack);
            timer_r <= timer_nxt_s;
            pkts_r  <= pkts_nxt_s;
            bytes_r <= bytes_nxt_s;
            if (!connected) begin
                pending_r <= 1'b0;
                reason_r  <= {ACK_RSN_W{1'b0}};
            end else if (done) begin
                pending_r <= |trig_s;
                reason_r  <= trig_s;
            end else begin
                pending_r <= pending_r | (|trig_s);
                reason_r  <= reason_r | trig_s;
            end
        end
    end

endmodule

// File: rtl/tcp_vlg_ack_ctl.sv
// Multi-channel delayed-ACK controller: per-channel trackers arbitrated
// round-robin onto the single TX pure-ACK request port.
module tcp_vlg_ack_ctl
    import tcp_vlg_pkg::*;
#(
    parameter int CHANNELS          = 4,
    parameter int TIMEOUT           = 1250,
    parameter int FORCE_ACK_PACKETS = 5,
    parameter int FORCE_ACK_BYTES   = 2920,
    parameter int IMM_OOO           = 1,
    parameter int IMM_PSH           = 0,
    localparam int CW = (CHANNELS > 32'sd1) ? $clog2(CHANNELS) : 32'sd1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [CHANNELS-1:0]        connected,
    input  logic [CHANNELS-1:0]        rx_val,
    input  logic [CHANNELS-1:0][31:0]  rx_seq_end,
    input  logic [CHANNELS-1:0][15:0]  rx_len,
    input  logic [CHANNELS-1:0]        rx_psh,
    input  logic [CHANNELS-1:0][31:0]  loc_ack,
    input  logic [CHANNELS-1:0][31:0]  rep_ack,
    input  logic [CHANNELS-1:0]        sack_upd,
    input  logic [CHANNELS-1:0]        win_upd,
    output logic                       tx_req,
    output logic [CW-1:0]              tx_ch,
    output logic [ACK_RSN_W-1:0]       tx_reason,
    input  logic                       tx_sent
);

    localparam int            IW      = CW + 32'sd1;
    localparam logic [IW-1:0] CH_CNT  = IW'(CHANNELS);
    localparam logic [CW-1:0] LAST_CH = CW'(CHANNELS - 32'sd1);

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_REQ  = 1'b1;

    logic                                state_r;
    logic                                tx_req_r;
    logic [CW-1:0]                       tx_ch_r;
    logic [CW-1:0]                       rr_ptr_r;

    logic [CHANNELS-1:0]                 pending_s;
    logic [CHANNELS-1:0][ACK_RSN_W-1:0]  reason_s;
    logic [CHANNELS-1:0]                 done_s;
    logic                                pick_vld_s;
    logic [CW-1:0]                       pick_ch_s;
    logic [IW-1:0]                       idx_s;
    ack_reason_t                         gnt_rsn_s;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
        assign done_s[c] = tx_sent && (state_r == ST_REQ) && (tx_ch_r == CW'(c));

        tcp_vlg_ack_chan #(
            .TIMEOUT           (TIMEOUT),
            .FORCE_ACK_PACKETS (FORCE_ACK_PACKETS),
            .FORCE_ACK_BYTES   (FORCE_ACK_BYTES),
            .IMM_OOO           (IMM_OOO),
            .IMM_PSH           (IMM_PSH)
        ) u_chan (
            .clk        (clk),
            .rst        (rst),
            .connected  (connected[c]),
            .rx_val     (rx_val[c]),
            .rx_seq_end (rx_seq_end[c]),
            .rx_len     (rx_len[c]),
            .rx_psh     (rx_psh[c]),
            .loc_ack    (loc_ack[c]),
            .rep_ack    (rep_ack[c]),
            .sack_upd   (sack_upd[c]),
            .win_upd    (win_upd[c]),
            .done       (done_s[c]),
            .pending    (pending_s[c]),
            .reason     (reason_s[c])
        );
    end

    assign tx_req    = tx_req_r;
    assign tx_ch     = tx_ch_r;
    assign tx_reason = gnt_rsn_s;

    // First pending channel at or after rr_ptr, wrapping modulo CHANNELS.
    always_comb begin
        pick_vld_s = 1'b0;
        pick_ch_s  = {CW{1'b0}};
        idx_s      = {IW{1'b0}};
        for (int i = 0; i < CHANNELS; i++) begin
            idx_s = {1'b0, rr_ptr_r} + IW'(i);
            if (idx_s >= CH_CNT) begin
                idx_s = idx_s - CH_CNT;
            end else begin
                idx_s = idx_s;
            end
            if (!pick_vld_s && pending_s[idx_s[CW-1:0]]) begin
                pick_vld_s = 1'b1;
                pick_ch_s  = idx_s[CW-1:0];
            end else begin
                pick_vld_s = pick_vld_s;
            end
        end
    end

    // Reason of the granted channel follows it live while the request is up.
    always_comb begin
        if (state_r == ST_REQ) begin
            gnt_rsn_s = ack_reason_t'(reason_s[tx_ch_r]);
        end else begin
            gnt_rsn_s = ack_reason_t'(7'b0000000);
        end
    end

    // Grant FSM; a disconnect of the granted channel abandons it without moving rr_ptr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_IDLE;
            tx_req_r <= 1'b0;
            tx_ch_r  <= {CW{1'b0}};
            rr_ptr_r <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (pick_vld_s) begin
                        state_r  <= ST_REQ;
                        tx_req_r <= 1'b1;
                        tx_ch_r  <= pick_ch_s;
                    end else begin
                        state_r  <= ST_IDLE;
                        tx_req_r <= 1'b0;
                    end
                end
                ST_REQ: begin
                    if (tx_sent) begin
                        state_r  <= ST_IDLE;
                        tx_req_r <= 1'b0;
                        rr_ptr_r <= (tx_ch_r == LAST_CH) ? {CW{1'b0}} : tx_ch_r + CW'(1'b1);
                    end else if (!connected[tx_ch_r]) begin
                        state_r  <= ST_IDLE;
                        tx_req_r <= 1'b0;
                    end else begin
                        state_r  <= ST_REQ;
                        tx_req_r <= 1'b1;
                    end
                end
                default: begin
                    state_r  <= ST_IDLE;
                    tx_req_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tcp_vlg_ack_ctl.sv
// Directed bench for tcp_vlg_ack_ctl: a 4-channel instance for arbitration and
// triggers, and a 1-channel short-timeout instance without immediate OOO ACKs.
module tb_tcp_vlg_ack_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic [3:0]        a_conn, a_rx_val, a_rx_psh, a_sack, a_win;
    logic [3:0][31:0]  a_seq_end, a_loc, a_rep;
    logic [3:0][15:0]  a_len;
    logic              a_tx_req, a_tx_sent;
    logic [1:0]        a_tx_ch;
    logic [6:0]        a_tx_reason;

    logic              b_conn, b_rx_val, b_rx_psh, b_sack, b_win, b_tx_req, b_tx_sent;
    logic [31:0]       b_seq_end, b_loc, b_rep;
    logic [15:0]       b_len;
    logic [0:0]        b_tx_ch;
    logic [6:0]        b_tx_reason;

    int n_chk = 0;
    int n_err = 0;

    tcp_vlg_ack_ctl #(
        .CHANNELS(4), .TIMEOUT(40), .FORCE_ACK_PACKETS(5),
        .FORCE_ACK_BYTES(2920), .IMM_OOO(1), .IMM_PSH(0)
    ) u_dut_a (
        .clk(clk), .rst(rst), .connected(a_conn), .rx_val(a_rx_val),
        .rx_seq_end(a_seq_end), .rx_len(a_len), .rx_psh(a_rx_psh),
        .loc_ack(a_loc), .rep_ack(a_rep), .sack_upd(a_sack), .win_upd(a_win),
        .tx_req(a_tx_req), .tx_ch(a_tx_ch), .tx_reason(a_tx_reason), .tx_sent(a_tx_sent)
    );

    tcp_vlg_ack_ctl #(
        .CHANNELS(1), .TIMEOUT(10), .FORCE_ACK_PACKETS(5),
        .FORCE_ACK_BYTES(2920), .IMM_OOO(0), .IMM_PSH(0)
    ) u_dut_b (
        .clk(clk), .rst(rst), .connected(b_conn), .rx_val(b_rx_val),
        .rx_seq_end(b_seq_end), .rx_len(b_len), .rx_psh(b_rx_psh),
        .loc_ack(b_loc), .rep_ack(b_rep), .sack_upd(b_sack), .win_upd(b_win),
        .tx_req(b_tx_req), .tx_ch(b_tx_ch), .tx_reason(b_tx_reason), .tx_sent(b_tx_sent)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic a_grant(input string tag, input logic [1:0] ch, input logic [6:0] rsn);
        chk({tag, "_req"}, {31'd0, a_tx_req}, 32'd1);
        chk({tag, "_ch"}, {30'd0, a_tx_ch}, {30'd0, ch});
        chk({tag, "_rsn"}, {25'd0, a_tx_reason}, {25'd0, rsn});
    endtask

    task automatic a_serve();
        a_tx_sent = 1'b1;
        tick();
        a_tx_sent = 1'b0;
        chk("a_sent_drop", {31'd0, a_tx_req}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        a_conn = 4'h0; a_rx_val = 4'h0; a_rx_psh = 4'h0; a_sack = 4'h0; a_win = 4'h0;
        a_seq_end = '0; a_loc = '0; a_rep = '0; a_len = '0; a_tx_sent = 1'b0;
        b_conn = 1'b0; b_rx_val = 1'b0; b_rx_psh = 1'b0; b_sack = 1'b0; b_win = 1'b0;
        b_seq_end = 32'd0; b_loc = 32'd0; b_rep = 32'd0; b_len = 16'd0; b_tx_sent = 1'b0;
        tick();
        tick();
        chk("rst_a_req", {31'd0, a_tx_req}, 32'd0);
        chk("rst_a_ch", {30'd0, a_tx_ch}, 32'd0);
        chk("rst_a_rsn", {25'd0, a_tx_reason}, 32'd0);
        chk("rst_b_req", {31'd0, b_tx_req}, 32'd0);
        rst = 1'b0;
        a_conn = 4'hF;
        b_conn = 1'b1;
        repeat (4) tick();
        chk("idle_a", {31'd0, a_tx_req}, 32'd0);

        // B: timeout measured from the first unacked cycle
        b_rx_val = 1'b1; b_seq_end = 32'd0; b_len = 16'd100;
        tick();
        b_rx_val = 1'b0; b_loc = 32'd100;
        repeat (11) tick();
        chk("to_early", {31'd0, b_tx_req}, 32'd0);
        tick();
        chk("to_req", {31'd0, b_tx_req}, 32'd1);
        chk("to_rsn", {25'd0, b_tx_reason}, 32'h01);
        b_tx_sent = 1'b1; b_rep = 32'd100;
        tick();
        b_tx_sent = 1'b0;
        chk("to_drop", {31'd0, b_tx_req}, 32'd0);
        repeat (15) tick();
        chk("to_clear", {31'd0, b_tx_req}, 32'd0);

        // B: out-of-order without immediate ACK only restarts the timer
        b_loc = 32'd200;
        tick();
        b_rx_val = 1'b1; b_seq_end = 32'd1200; b_len = 16'd10;
        tick();
        b_rx_val = 1'b0;
        tick();
        chk("noimm_d3", {31'd0, b_tx_req}, 32'd0);
        repeat (9) tick();
        chk("noimm_d12", {31'd0, b_tx_req}, 32'd0);
        tick();
        chk("noimm_req", {31'd0, b_tx_req}, 32'd1);
        chk("noimm_rsn", {25'd0, b_tx_reason}, 32'h01);
        b_tx_sent = 1'b1; b_rep = 32'd200;
        tick();
        b_tx_sent = 1'b0;
        repeat (3) tick();
        chk("noimm_clear", {31'd0, b_tx_req}, 32'd0);

        // A: immediate out-of-order ACK on ch1
        a_rx_val = 4'b0010; a_seq_end[1] = 32'd1000; a_len[1] = 16'd0;
        tick();
        a_rx_val = 4'b0000;
        chk("ooo_lat", {31'd0, a_tx_req}, 32'd0);
        tick();
        a_grant("ooo", 2'd1, 7'b0001000);
        a_serve();

        // A: five in-order segments on ch2, then a redundant ACK as rep catches up late
        a_loc[2] = 32'd1000;
        tick();
        for (int k = 0; k < 5; k++) begin
            a_rx_val = 4'b0100; a_seq_end[2] = 32'd1000; a_len[2] = 16'd100;
            tick();
        end
        a_rx_val = 4'b0000;
        chk("pkts_d6", {31'd0, a_tx_req}, 32'd0);
        tick();
        chk("pkts_d7", {31'd0, a_tx_req}, 32'd0);
        tick();
        a_grant("pkts", 2'd2, 7'b0000010);
        a_rep[2] = 32'd1000;
        a_serve();
        tick();
        a_grant("redund", 2'd2, 7'b0000010);
        a_serve();
        repeat (3) tick();
        chk("pkts_clear", {31'd0, a_tx_req}, 32'd0);

        // A: window reopen on ch3
        a_win = 4'b1000;
        tick();
        a_win = 4'b0000;
        tick();
        a_grant("win", 2'd3, 7'b1000000);
        a_serve();

        // A: round-robin 0,1,3 with a late ch0 request served after ch3
        a_sack = 4'b1011;
        tick();
        a_sack = 4'b0000;
        chk("rr_lat", {31'd0, a_tx_req}, 32'd0);
        tick();
        a_grant("rr0", 2'd0, 7'b0100000);
        a_serve();
        tick();
        a_grant("rr1", 2'd1, 7'b0100000);
        a_sack = 4'b0001;
        tick();
        a_sack = 4'b0000;
        a_grant("rr1_hold", 2'd1, 7'b0100000);
        a_serve();
        tick();
        a_grant("rr3", 2'd3, 7'b0100000);
        a_serve();
        tick();
        a_grant("rr0b", 2'd0, 7'b0100000);
        a_serve();

        // A: sack in the same cycle as completion keeps only the new reason
        a_win = 4'b0001;
        tick();
        a_win = 4'b0000;
        tick();
        a_grant("sim_first", 2'd0, 7'b1000000);
        a_sack = 4'b0001;
        a_serve();
        a_sack = 4'b0000;
        tick();
        a_grant("sim_again", 2'd0, 7'b0100000);
        a_serve();
        a_tx_sent = 1'b1;
        tick();
        a_tx_sent = 1'b0;
        chk("idle_sent", {31'd0, a_tx_req}, 32'd0);

        // A: granted ch1 disconnects; rr_ptr stays at 1 and ch1 reason is wiped
        a_win = 4'b0010;
        tick();
        a_win = 4'b0000;
        tick();
        a_grant("disc_gnt", 2'd1, 7'b1000000);
        a_conn[1] = 1'b0;
        tick();
        chk("disc_drop", {31'd0, a_tx_req}, 32'd0);
        a_conn[1] = 1'b1;
        tick();
        a_sack = 4'b0110;
        tick();
        a_sack = 4'b0000;
        tick();
        a_grant("disc_rr1", 2'd1, 7'b0100000);
        a_serve();
        tick();
        a_grant("disc_rr2", 2'd2, 7'b0100000);
        a_serve();

        // A: byte-count trigger on ch3 (2 x 1500 >= 2920, only two packets)
        a_loc[3] = 32'd5000; a_rep[3] = 32'd4000;
        tick();
        for (int k = 0; k < 2; k++) begin
            a_rx_val = 4'b1000; a_seq_end[3] = 32'd5000; a_len[3] = 16'd1500;
            tick();
        end
        a_rx_val = 4'b0000;
        a_rep[3] = 32'd5000;
        chk("bytes_d3", {31'd0, a_tx_req}, 32'd0);
        tick();
        chk("bytes_d4", {31'd0, a_tx_req}, 32'd0);
        tick();
        a_grant("bytes", 2'd3, 7'b0000100);
        a_serve();
        repeat (3) tick();
        chk("bytes_clear", {31'd0, a_tx_req}, 32'd0);

        // A: reset while a request is up
        a_win = 4'b0100;
        tick();
        a_win = 4'b0000;
        tick();
        a_grant("pre_rst", 2'd2, 7'b1000000);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_req", {31'd0, a_tx_req}, 32'd0);
        chk("mid_rst_ch", {30'd0, a_tx_ch}, 32'd0);
        chk("mid_rst_rsn", {25'd0, a_tx_reason}, 32'd0);
        repeat (5) tick();
        chk("post_rst", {31'd0, a_tx_req}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
